jtag_pin_sync: RTL and testbench
================================

// Module: jtag_pin_sync
// PURPOSE
//   Front-end stage between the raw JTAG pins (tclk/tms/tdi/trst) and the debug transport module.
//   Synchronises and glitch-filters the pins into the system clk domain.
//   Emits single-cycle TCK edge strobes with aligned TMS/TDI samples and detects TAP reset.
//   Registers DTM TDO/enable on TCK falling edge to drive the top-level TDO tristate buffer.
// PARAMETERS
//   SYNC_STAGES  2     flops per input synchroniser chain (>=2)
//   FILTER_LEN   2     consecutive equal synced samples required to accept a tclk level change (>=1)
//   TRST_POL     1'b0  active level of trst pin (0 = active-low)
// PORTS
//   clk          in   1  system clock; all logic on rising edge
//   rst          in   1  synchronous reset, active-high
//   tclk_i       in   1  raw JTAG TCK pin (asynchronous)
//   tms_i        in   1  raw JTAG TMS pin
//   tdi_i        in   1  raw JTAG TDI pin
//   trst_i       in   1  raw JTAG TRST pin, polarity per TRST_POL
//   tck_rise     out  1  1-cycle strobe: filtered TCK rising edge
//   tck_fall     out  1  1-cycle strobe: filtered TCK falling edge
//   tms          out  1  TMS sampled at last tck_rise
//   tdi          out  1  TDI sampled at last tck_rise
//   tap_reset    out  1  TAP must enter Test-Logic-Reset
//   tdo_d        in   1  TDO bit from DTM
//   tdo_en_d     in   1  TDO drive enable from DTM
//   tdo          out  1  registered TDO to pad buffer
//   tdo_en       out  1  registered TDO enable (active-high; top inverts for OEN)
// BEHAVIOUR
//   Reset (rst=1): sync chains clear (tclk 0, tms 1, tdi 0, trst inactive); filter count 0;
//     tck_rise=tck_fall=0, tms=1, tdi=0, tdo=0, tdo_en=0, tap_reset=1, TMS-high count 0.
//   Sync: each pin passes SYNC_STAGES flops; tclk_s, tms_s, tdi_s, trst_s are last-stage outputs.
//   Filter: tclk_f holds level; cnt increments while tclk_s != tclk_f, clears when equal;
//     when cnt reaches FILTER_LEN, tclk_f <= tclk_s and cnt <= 0. Glitches < FILTER_LEN cycles ignored.
//   Edges: tck_rise=1 for exactly the cycle after tclk_f goes 0->1; tck_fall for 1->0.
//     Pin edge to strobe latency = SYNC_STAGES+FILTER_LEN+1 clk cycles (+/-1 for async phase).
//     TMS/TDI take the same path length without filtering, delayed to align with tclk_f.
//     tms/tdi outputs update in the tck_rise cycle and hold until the next tck_rise.
//   TDO: on tck_fall cycle, tdo<=tdo_d and tdo_en<=tdo_en_d (visible next cycle); held otherwise.
//   TAP reset FSM: states RUN, HIGH_CNT(1..4), TLR.
//     Each tck_rise with tms=1 advances the count; the 5th consecutive enters TLR.
//     Any tck_rise with tms=0 returns to RUN (count 0).
//     tap_reset=1 for exactly one cycle on TLR entry. FSM stays in TLR until a tms=0 rise.
//     No further pulses while in TLR.
//   TRST: while trst_s active, tap_reset=1 (level), strobes forced 0, tms=1, tdo_en=0.
//     FSM forced to TLR. On release, tap_reset drops next cycle.
//   Simultaneous: trst active and tclk_f edge in same cycle -> strobe suppressed, trst wins.
//     rst wins over everything.
//   Timing constraint: tclk high and low each >= SYNC_STAGES+FILTER_LEN+2 clk cycles.
//     Faster TCK is out of spec; edges may be lost but strobes never overlap (rise/fall mutually exclusive).
//   Reset mid-operation: all state returns to reset values in the next cycle; partial filter count discarded.
// TESTING
//   1. Reset, then tclk 0->1 held 10 clk, tms_i=0, tdi_i=1 -> one tck_rise 5 cycles after edge;
//      tms=0, tdi=1 from that cycle on.
//   2. tclk glitch high for 1 clk (FILTER_LEN=2) -> no tck_rise, no tck_fall, tclk_f stays 0.
//   3. tdo_d=1, tdo_en_d=1, tclk falling edge -> tdo=1, tdo_en=1 one cycle after tck_fall; tdo_d toggles w/o edge -> tdo unchanged.
//   4. 5 TCK rises with tms_i=1 -> tap_reset pulses 1 cycle after 5th rise only; 6th,7th rise no pulse; tms=0 rise then 5 more -> pulse again.
//   5. trst_i=0 (TRST_POL=0) for 8 clk during TCK toggling -> tap_reset high, tck_rise/fall 0, tdo_en=0; release -> strobes resume.
//   6. rst asserted mid-filter and with tdo_en=1 -> next cycle tdo_en=0, tap_reset=1, no spurious strobe after rst release with tclk_i=0.

Source files
------------

// File: rtl/jtag_pin_sync.sv
// JTAG pin front-end: synchronises and glitch-filters the raw TAP pins into
// the clk domain, produces TCK edge strobes with aligned TMS/TDI samples,
// tracks TAP reset (five TMS-high rises or TRST) and registers TDO for the pad.
module jtag_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 2,
    parameter logic        TRST_POL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tclk_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trst_i,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms,
    output logic tdi,
    output logic tap_reset,
    input  logic tdo_d,
    input  logic tdo_en_d,
    output logic tdo,
    output logic tdo_en
);

    // Counter only needs to reach FILTER_LEN-1 before the level is accepted.
    localparam int unsigned CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        ST_RUN = 3'd0,
        ST_H1  = 3'd1,
        ST_H2  = 3'd2,
        ST_H3  = 3'd3,
        ST_H4  = 3'd4,
        ST_TLR = 3'd5
    } tap_state_e;

    logic [SYNC_STAGES-1:0] tclk_sync_q;
    logic [SYNC_STAGES-1:0] tms_sync_q;
    logic [SYNC_STAGES-1:0] tdi_sync_q;
    logic [SYNC_STAGES-1:0] trst_sync_q;
    logic [FILTER_LEN-1:0]  tms_dly_q;
    logic [FILTER_LEN-1:0]  tdi_dly_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tclk_f_q;
    logic                   tclk_f_dly_q;
    logic                   tck_rise_q;
    logic                   tck_fall_q;
    logic                   tms_q;
    logic                   tdi_q;
    logic                   tdo_q;
    logic                   tdo_en_q;
    logic                   tap_reset_q;
    tap_state_e             state_q;
    tap_state_e             state_d;

    logic tclk_s;
    logic tms_s;
    logic tdi_s;
    logic trst_act_c;
    logic rise_c;
    logic fall_c;
    logic tlr_entry_c;

    assign tclk_s     = tclk_sync_q[SYNC_STAGES-1];
    assign tms_s      = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s      = tdi_sync_q[SYNC_STAGES-1];
    assign trst_act_c = (trst_sync_q[SYNC_STAGES-1] == TRST_POL);

    // Edges of the filtered clock; TRST suppresses any strobe in the same cycle.
    assign rise_c = tclk_f_q & ~tclk_f_dly_q & ~trst_act_c;
    assign fall_c = ~tclk_f_q & tclk_f_dly_q & ~trst_act_c;

    // Multi-flop synchronisers for every asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            tclk_sync_q <= '0;
            tms_sync_q  <= '1;
            tdi_sync_q  <= '0;
            trst_sync_q <= {SYNC_STAGES{~TRST_POL}};
        end else begin
            tclk_sync_q <= {tclk_sync_q[SYNC_STAGES-2:0], tclk_i};
            tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], tms_i};
            tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], tdi_i};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], trst_i};
        end
    end

    // Delay TMS/TDI by the filter depth so they line up with the filtered TCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            tms_dly_q <= '1;
            tdi_dly_q <= '0;
        end else begin
            tms_dly_q[0] <= tms_s;
            tdi_dly_q[0] <= tdi_s;
            for (int i = 1; i < int'(FILTER_LEN); i++) begin
                tms_dly_q[i] <= tms_dly_q[i-1];
                tdi_dly_q[i] <= tdi_dly_q[i-1];
            end
        end
    end

    // TCK glitch filter: a new level must persist FILTER_LEN samples to be taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            tclk_f_q <= 1'b0;
            cnt_q    <= '0;
        end else if (tclk_s != tclk_f_q) begin
            if (cnt_q == CNT_LAST) begin
                tclk_f_q <= tclk_s;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Strobes, sampled TMS/TDI, TDO capture on TCK fall and TAP reset output.
    always_ff @(posedge clk) begin
        if (rst) begin
            tclk_f_dly_q <= 1'b0;
            tck_rise_q   <= 1'b0;
            tck_fall_q   <= 1'b0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b0;
            tdo_q        <= 1'b0;
            tdo_en_q     <= 1'b0;
            tap_reset_q  <= 1'b1;
        end else begin
            tclk_f_dly_q <= tclk_f_q;
            tck_rise_q   <= rise_c;
            tck_fall_q   <= fall_c;
            if (trst_act_c) begin
                tms_q <= 1'b1;
            end else if (rise_c) begin
                tms_q <= tms_dly_q[FILTER_LEN-1];
                tdi_q <= tdi_dly_q[FILTER_LEN-1];
            end
            if (trst_act_c) begin
                tdo_en_q <= 1'b0;
            end else if (tck_fall_q) begin
                tdo_q    <= tdo_d;
                tdo_en_q <= tdo_en_d;
            end
            tap_reset_q <= trst_act_c | tlr_entry_c;
        end
    end

    // TAP reset tracker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: count consecutive TMS-high rises, TRST forces Test-Logic-Reset.
    always_comb begin
        state_d = state_q;
        if (trst_act_c) begin
            state_d = ST_TLR;
        end else if (tck_rise_q) begin
            if (!tms_q) begin
                state_d = ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN:  state_d = ST_H1;
                    ST_H1:   state_d = ST_H2;
                    ST_H2:   state_d = ST_H3;
                    ST_H3:   state_d = ST_H4;
                    ST_H4:   state_d = ST_TLR;
                    ST_TLR:  state_d = ST_TLR;
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    // Output decode: flag the single cycle in which Test-Logic-Reset is entered.
    always_comb begin
        tlr_entry_c = 1'b0;
        if ((state_d == ST_TLR) && (state_q != ST_TLR) && !trst_act_c) begin
            tlr_entry_c = 1'b1;
        end
    end

    assign tck_rise  = tck_rise_q;
    assign tck_fall  = tck_fall_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign tap_reset = tap_reset_q;
    assign tdo       = tdo_q;
    assign tdo_en    = tdo_en_q;

endmodule

// File: tb/tb_jtag_pin_sync.sv
// Directed bench for jtag_pin_sync with default parameters.
module tb_jtag_pin_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tclk_i = 1'b0;
    logic tms_i = 1'b0;
    logic tdi_i = 1'b1;
    logic trst_i = 1'b1;
    logic tdo_d = 1'b0;
    logic tdo_en_d = 1'b0;
    logic tck_rise, tck_fall, tms, tdi, tap_reset, tdo, tdo_en;

    jtag_pin_sync #(.SYNC_STAGES(2), .FILTER_LEN(2), .TRST_POL(1'b0)) dut (
        .clk(clk), .rst(rst), .tclk_i(tclk_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .trst_i(trst_i), .tck_rise(tck_rise), .tck_fall(tck_fall), .tms(tms),
        .tdi(tdi), .tap_reset(tap_reset), .tdo_d(tdo_d), .tdo_en_d(tdo_en_d),
        .tdo(tdo), .tdo_en(tdo_en)
    );

    always #5 clk = ~clk;

    // in = {rst,tclk,tms,tdi,trst,tdo_d,tdo_en_d}; ex = {rise,fall,tms,tdi,tap_reset,tdo,tdo_en}
    typedef struct packed {
        logic [6:0] in;
        logic [6:0] ex;
    } vec_t;

    vec_t vq[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rise = 0;
    int n_fall = 0;
    int n_tr = 0;
    int last_rise_cyc = 0;
    int last_tr_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tck_rise === 1'b1) begin
            n_rise++;
            last_rise_cyc = cyc;
        end
        if (tck_fall === 1'b1) n_fall++;
        if (tap_reset === 1'b1) begin
            n_tr++;
            last_tr_cyc = cyc;
        end
        chk("strobe_exclusive", 32'(tck_rise & tck_fall), 32'd0);
    endtask

    task automatic add(input logic [6:0] in, input logic [6:0] ex, input int n);
        vec_t v;
        v.in = in;
        v.ex = ex;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    // One full TCK period with the given TMS, half-periods well above the minimum.
    task automatic pulse(input logic t);
        tms_i = t;
        repeat (2) tick();
        tclk_i = 1'b1;
        repeat (8) tick();
        tclk_i = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, t0;
        logic [6:0] ex;
        logic [6:0] got;

        add(7'b1001100, 7'b0010100, 3);  // reset
        add(7'b0001100, 7'b0010000, 4);  // idle, tms_i=0 tdi_i=1
        add(7'b0101100, 7'b0010000, 4);  // tclk rises, pipeline filling
        add(7'b0101100, 7'b1001000, 1);  // tck_rise 5 cycles after pin edge
        add(7'b0101100, 7'b0001000, 5);
        add(7'b0001111, 7'b0001000, 4);  // tclk falls, tdo_d=tdo_en_d=1
        add(7'b0001111, 7'b0101000, 1);  // tck_fall
        add(7'b0001111, 7'b0001011, 1);  // tdo/tdo_en captured
        add(7'b0001101, 7'b0001011, 4);  // tdo_d toggles without edge
        add(7'b0101101, 7'b0001011, 1);  // 1-cycle glitch high
        add(7'b0001101, 7'b0001011, 7);  // glitch rejected

        foreach (vq[i]) begin
            {rst, tclk_i, tms_i, tdi_i, trst_i, tdo_d, tdo_en_d} = vq[i].in;
            tick();
            ex  = vq[i].ex;
            got = {tck_rise, tck_fall, tms, tdi, tap_reset, tdo, tdo_en};
            chk($sformatf("vec%0d.tck_rise", i),  32'(got[6]), 32'(ex[6]));
            chk($sformatf("vec%0d.tck_fall", i),  32'(got[5]), 32'(ex[5]));
            chk($sformatf("vec%0d.tms", i),       32'(got[4]), 32'(ex[4]));
            chk($sformatf("vec%0d.tdi", i),       32'(got[3]), 32'(ex[3]));
            chk($sformatf("vec%0d.tap_reset", i), 32'(got[2]), 32'(ex[2]));
            chk($sformatf("vec%0d.tdo", i),       32'(got[1]), 32'(ex[1]));
            chk($sformatf("vec%0d.tdo_en", i),    32'(got[0]), 32'(ex[0]));
        end

        // Five consecutive TMS-high rises enter Test-Logic-Reset once.
        pulse(1'b0);
        r0 = n_rise;
        t0 = n_tr;
        for (int k = 1; k <= 5; k++) begin
            pulse(1'b1);
            chk($sformatf("t4_rises_%0d", k), 32'(n_rise - r0), 32'(k));
            chk($sformatf("t4_tap_reset_%0d", k), 32'(n_tr - t0), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("t4_pulse_latency", 32'(last_tr_cyc - last_rise_cyc), 32'd1);
        pulse(1'b1);
        pulse(1'b1);
        chk("t4_no_pulse_in_tlr", 32'(n_tr - t0), 32'd1);
        pulse(1'b0);
        t0 = n_tr;
        for (int k = 1; k <= 5; k++) pulse(1'b1);
        chk("t4_second_pulse", 32'(n_tr - t0), 32'd1);

        // TRST asserted while TCK toggles: strobes suppressed, tap_reset level.
        tdo_en_d = 1'b1;
        pulse(1'b0);
        chk("t5_tdo_en_before", 32'(tdo_en), 32'd1);
        tclk_i = 1'b1;
        repeat (2) tick();
        r0 = n_rise;
        f0 = n_fall;
        trst_i = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 3) tclk_i = 1'b0;
            if (j >= 4) begin
                chk($sformatf("t5_tap_reset_%0d", j), 32'(tap_reset), 32'd1);
                chk($sformatf("t5_tck_rise_%0d", j),  32'(tck_rise), 32'd0);
                chk($sformatf("t5_tck_fall_%0d", j),  32'(tck_fall), 32'd0);
                chk($sformatf("t5_tdo_en_%0d", j),    32'(tdo_en), 32'd0);
                chk($sformatf("t5_tms_%0d", j),       32'(tms), 32'd1);
            end
        end
        trst_i = 1'b1;
        repeat (2) tick();
        chk("t5_no_rise", 32'(n_rise - r0), 32'd0);
        chk("t5_no_fall", 32'(n_fall - f0), 32'd0);
        repeat (4) tick();
        chk("t5_tap_reset_released", 32'(tap_reset), 32'd0);
        r0 = n_rise;
        f0 = n_fall;
        pulse(1'b0);
        chk("t5_rise_resumes", 32'(n_rise - r0), 32'd1);
        chk("t5_fall_resumes", 32'(n_fall - f0), 32'd1);

        // Reset in the middle of a filter run with the output enable set.
        chk("t6_tdo_en_before", 32'(tdo_en), 32'd1);
        tclk_i = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tclk_i = 1'b0;
        tick();
        chk("t6_tdo_en", 32'(tdo_en), 32'd0);
        chk("t6_tap_reset", 32'(tap_reset), 32'd1);
        chk("t6_tck_rise", 32'(tck_rise), 32'd0);
        chk("t6_tms", 32'(tms), 32'd1);
        chk("t6_tdi", 32'(tdi), 32'd0);
        chk("t6_tdo", 32'(tdo), 32'd0);
        rst = 1'b0;
        r0 = n_rise;
        f0 = n_fall;
        repeat (12) tick();
        chk("t6_no_rise", 32'(n_rise - r0), 32'd0);
        chk("t6_no_fall", 32'(n_fall - f0), 32'd0);
        chk("t6_tap_reset_low", 32'(tap_reset), 32'd0);
        chk("t6_tdo_en_low", 32'(tdo_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
